// File: rtl/div_wb_buffer.sv
// Divider writeback buffer: tracks the single in-flight divide tag and queues finished results for writeback.
// Optional DIV_WB_BYPASS_EN macro forwards a finishing result straight to wb_* when the queue is empty.
module div_wb_buffer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_en,
   input  logic [TAG_W-1:0]           issue_rd,
   input  logic                       fu_finish,
   input  logic [31:0]                fu_res,
   output logic                       div_busy,
   output logic                       wb_valid,
   output logic [31:0]                wb_data,
   output logic [TAG_W-1:0]           wb_rd,
   input  logic                       wb_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = TAG_W + 32;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} pend_state_t;

   pend_state_t        state_r;
   logic [TAG_W-1:0]   pend_rd_r;
   logic [EW-1:0]      mem_r [DEPTH];
   logic [PW-1:0]      wr_ptr_r;
   logic [PW-1:0]      rd_ptr_r;
   logic [CW-1:0]      count_r;
   logic               err_r;

   logic               pend_v_s;
   logic               full_s;
   logic               head_v_s;
   logic               accept_s;
   logic               finish_ok_s;
   logic               push_s;
   logic               pop_s;
   logic               viol_s;
   logic               byp_s;

   assign pend_v_s    = (state_r == WAIT);
   assign full_s      = (count_r == CW'(DEPTH));
   assign head_v_s    = (count_r != {CW{1'b0}});
   assign div_busy    = pend_v_s | full_s;
   assign accept_s    = issue_en & ~div_busy;
   assign finish_ok_s = fu_finish & pend_v_s;
   assign pop_s       = head_v_s & wb_ready;
   assign viol_s      = (fu_finish & ~pend_v_s) | (issue_en & div_busy);
   assign count       = count_r;
   assign err         = err_r;

`ifdef DIV_WB_BYPASS_EN
   assign byp_s  = finish_ok_s & ~head_v_s;
   // A bypassed result consumed by writeback this cycle never enters the queue.
   assign push_s = finish_ok_s & ~(byp_s & wb_ready);
`else
   assign byp_s  = 1'b0;
   assign push_s = finish_ok_s;
`endif

   // Pending-tag tracker: at most one divide is in flight at a time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         pend_rd_r <= {TAG_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r   <= WAIT;
                  pend_rd_r <= issue_rd;
               end
            end
            WAIT: begin
               if (fu_finish) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Result storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {pend_rd_r, fu_res};
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky protocol-violation flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (viol_s) begin
         err_r <= 1'b1;
      end
   end

   // Writeback presentation: head entry, or the finishing result when bypassing.
   always_comb begin
      wb_valid = 1'b0;
      wb_data  = 32'h0000_0000;
      wb_rd    = {TAG_W{1'b0}};
      if (byp_s) begin
         wb_valid = 1'b1;
         wb_data  = fu_res;
         wb_rd    = pend_rd_r;
      end else if (head_v_s) begin
         wb_valid = 1'b1;
         wb_data  = mem_r[rd_ptr_r][31:0];
         wb_rd    = mem_r[rd_ptr_r][EW-1:32];
      end else begin
         wb_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_div_wb_buffer.sv
// Self-checking bench for div_wb_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_div_wb_buffer;

   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   logic              clk;
   logic              rst;
   logic              issue_en;
   logic [TAG_W-1:0]  issue_rd;
   logic              fu_finish;
   logic [31:0]       fu_res;
   logic              div_busy;
   logic              wb_valid;
   logic [31:0]       wb_data;
   logic [TAG_W-1:0]  wb_rd;
   logic              wb_ready;
   logic [2:0]        count;
   logic              err;

   int tests = 0;
   int fails = 0;

   // Reference model: pending flag/tag, ordered result queue, sticky error.
   bit                 m_pend;
   logic [TAG_W-1:0]   m_prd;
   logic [TAG_W+31:0]  m_q[$];
   bit                 m_err;

   div_wb_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .issue_en(issue_en), .issue_rd(issue_rd),
      .fu_finish(fu_finish), .fu_res(fu_res), .div_busy(div_busy),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
      .wb_ready(wb_ready), .count(count), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [42:0] obs_vec();
      return {wb_valid, wb_data, wb_rd, count, div_busy, err};
   endfunction

   function automatic logic [42:0] exp_vec();
      logic [TAG_W+31:0] h;
      logic              busy;
      h    = (m_q.size() != 0) ? m_q[0] : '0;
      busy = m_pend || (m_q.size() == DEPTH);
      return {m_q.size() != 0, h[31:0], h[TAG_W+31:32], 3'(m_q.size()), busy, m_err};
   endfunction

   // Apply one cycle of inputs, advance the model, then return inputs to idle before sampling.
   task automatic cycle(input logic en, input logic [TAG_W-1:0] rd, input logic fin,
                        input logic [31:0] res, input logic rdy, input logic r);
      bit busy;
      bit byp_take;
      issue_en = en; issue_rd = rd; fu_finish = fin; fu_res = res; wb_ready = rdy; rst = r;
      busy = m_pend || (m_q.size() == DEPTH);
      if (r) begin
         m_pend = 0; m_q.delete(); m_err = 0;
      end else begin
         if ((fin && !m_pend) || (en && busy)) m_err = 1;
         byp_take = 0;
`ifdef DIV_WB_BYPASS_EN
         byp_take = fin && m_pend && (m_q.size() == 0) && rdy;
`endif
         if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
         if (fin && m_pend) begin
            if (!byp_take) m_q.push_back({m_prd, res});
            m_pend = 0;
         end else if (en && !busy) begin
            m_pend = 1; m_prd = rd;
         end
      end
      @(posedge clk);
      #1;
      issue_en = 1'b0; fu_finish = 1'b0; fu_res = 32'h0; rst = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
      tests++;
      if (obs_vec() !== 43'h0) begin
         fails++; $display("FAIL reset: got %h expected %h", obs_vec(), 43'h0);
      end
   endtask

   task automatic test_single();
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 5'd7, 1'b0, 32'h0, 1'b1, 1'b0);
      tests++;
      if (div_busy !== 1'b1) begin
         fails++; $display("FAIL single_busy: got %b expected 1", div_busy);
      end
      cycle(1'b0, 5'd0, 1'b1, 32'h5, 1'b1, 1'b0);
      tests++;
      if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, 32'h5}) begin
         fails++; $display("FAIL single_wb: got v=%b rd=%0d d=%h expected v=1 rd=7 d=5", wb_valid, wb_rd, wb_data);
      end
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
      tests++;
      if (count !== 3'd0 || obs_vec() !== exp_vec()) begin
         fails++; $display("FAIL single_drain: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_fill();
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, 5'(i), 1'b0, 32'h0, 1'b0, 1'b0);
         cycle(1'b0, 5'd0, 1'b1, 32'h10 + 32'(i - 1), 1'b0, 1'b0);
      end
      tests++;
      if (count !== 3'd4 || div_busy !== 1'b1) begin
         fails++; $display("FAIL fill_full: got count=%0d busy=%b expected count=4 busy=1", count, div_busy);
      end
      for (int i = 1; i <= 4; i++) begin
         tests++;
         if (wb_valid !== 1'b1 || wb_rd !== 5'(i) || wb_data !== 32'h10 + 32'(i - 1)) begin
            fails++; $display("FAIL fill_pop%0d: got v=%b rd=%0d d=%h expected v=1 rd=%0d d=%h",
                              i, wb_valid, wb_rd, wb_data, i, 32'h10 + 32'(i - 1));
         end
         cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
      end
      tests++;
      if (obs_vec() !== exp_vec() || wb_valid !== 1'b0) begin
         fails++; $display("FAIL fill_empty: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_simultaneous();
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b1, 5'd3, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 5'd0, 1'b1, 32'hA, 1'b0, 1'b0);
      cycle(1'b1, 5'd4, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 5'd0, 1'b1, 32'hB, 1'b0, 1'b0);
      cycle(1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 5'd0, 1'b1, 32'hC, 1'b1, 1'b0);
      tests++;
      if (count !== 3'd2 || wb_rd !== 5'd4 || wb_data !== 32'hB) begin
         fails++; $display("FAIL simul_push_pop: got count=%0d rd=%0d d=%h expected count=2 rd=4 d=b", count, wb_rd, wb_data);
      end
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
      tests++;
      if (wb_rd !== 5'd5 || wb_data !== 32'hC || count !== 3'd1) begin
         fails++; $display("FAIL simul_order: got rd=%0d d=%h count=%0d expected rd=5 d=c count=1", wb_rd, wb_data, count);
      end
   endtask

   task automatic test_errors();
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b0, 5'd0, 1'b1, 32'h77, 1'b0, 1'b0);
      tests++;
      if (err !== 1'b1 || count !== 3'd0) begin
         fails++; $display("FAIL stray_finish: got err=%b count=%0d expected err=1 count=0", err, count);
      end
      cycle(1'b1, 5'd9, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 5'd12, 1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 5'd0, 1'b1, 32'h99, 1'b0, 1'b0);
      tests++;
      if (wb_rd !== 5'd9 || wb_data !== 32'h99 || err !== 1'b1) begin
         fails++; $display("FAIL busy_issue: got rd=%0d d=%h err=%b expected rd=9 d=99 err=1", wb_rd, wb_data, err);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
      tests++;
      if (err !== 1'b1) begin
         fails++; $display("FAIL err_sticky: got %b expected 1", err);
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 5'(20 + i), 1'b0, 32'h0, 1'b0, 1'b0);
         cycle(1'b0, 5'd0, 1'b1, 32'(i), 1'b0, 1'b0);
      end
      cycle(1'b1, 5'd30, 1'b0, 32'h0, 1'b0, 1'b0);
      tests++;
      if (count !== 3'd3 || div_busy !== 1'b1) begin
         fails++; $display("FAIL mid_setup: got count=%0d busy=%b expected count=3 busy=1", count, div_busy);
      end
      cycle(1'b0, 5'd0, 1'b1, 32'h55, 1'b0, 1'b1);
      tests++;
      if (obs_vec() !== 43'h0) begin
         fails++; $display("FAIL mid_reset: got %h expected %h", obs_vec(), 43'h0);
      end
      cycle(1'b0, 5'd0, 1'b1, 32'h66, 1'b1, 1'b0);
      tests++;
      if (err !== 1'b1 || count !== 3'd0) begin
         fails++; $display("FAIL post_reset_finish: got err=%b count=%0d expected err=1 count=0", err, count);
      end
   endtask

`ifdef DIV_WB_BYPASS_EN
   task automatic test_bypass();
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 5'd11, 1'b0, 32'h0, 1'b1, 1'b0);
      fu_finish = 1'b1; fu_res = 32'hDEADBEEF; wb_ready = 1'b1;
      #1;
      tests++;
      if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_rd !== 5'd11) begin
         fails++; $display("FAIL bypass_same_cycle: got v=%b d=%h rd=%0d expected v=1 d=deadbeef rd=11", wb_valid, wb_data, wb_rd);
      end
      m_pend = 0;
      @(posedge clk);
      #1;
      fu_finish = 1'b0; fu_res = 32'h0;
      tests++;
      if (count !== 3'd0 || wb_valid !== 1'b0) begin
         fails++; $display("FAIL bypass_no_push: got count=%0d v=%b expected count=0 v=0", count, wb_valid);
      end
   endtask
`endif

   task automatic test_random();
      cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 5'($urandom), ($urandom_range(0, 9) < 4),
               $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2));
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1; issue_en = 1'b0; issue_rd = '0; fu_finish = 1'b0; fu_res = 32'h0; wb_ready = 1'b0;
      m_pend = 0; m_prd = '0; m_err = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_fill();
      test_simultaneous();
      test_errors();
      test_reset_mid();
`ifdef DIV_WB_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/div_wb_buffer.md
DIV_WB_BUFFER -- requirements
Module: div_wb_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of result entries; legal values 2, 4 or 8.
REQ-002 Parameter: TAG_W, default 5, width of the destination-register tag.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: issue_en  input  1  the issue stage dispatches one divide to the divider this cycle.
REQ-006 Port: issue_rd  input  TAG_W  destination tag of the dispatched divide.
REQ-007 Port: fu_finish  input  1  one-cycle result-valid pulse from the divider.
REQ-008 Port: fu_res  input  32  divider quotient; valid only while fu_finish=1.
REQ-009 Port: div_busy  output  1  the issue stage shall not dispatch a divide while this is 1.
REQ-010 Port: wb_valid  output  1  head entry is presented to writeback.
REQ-011 Port: wb_data  output  32  head result.
REQ-012 Port: wb_rd  output  TAG_W  head destination tag.
REQ-013 Port: wb_ready  input  1  writeback accepts the head this cycle.
REQ-014 Port: count  output  log2(DEPTH)+1  number of occupied entries.
REQ-015 Port: err  output  1  sticky protocol-violation flag.

Function
REQ-016 The block shall hold a one-entry pending-tag register (pend_v, pend_rd) and a DEPTH-entry FIFO of {rd, data}.
REQ-017 Issue accepted = issue_en & ~div_busy; on accept: pend_v<=1, pend_rd<=issue_rd.
REQ-018 div_busy = pend_v | (count == DEPTH), purely combinational.
REQ-019 The pending-tag register shall use two states: IDLE (pend_v=0) and WAIT (pend_v=1); IDLE->WAIT on accepted issue; WAIT->IDLE on fu_finish.
REQ-020 On fu_finish with pend_v=1: push {pend_rd, fu_res}; pend_v<=0.
REQ-021 A push shall always find a free slot, because issue is accepted only when count<DEPTH and count never rises while in WAIT.
REQ-022 Pop = wb_valid & wb_ready; the head advances one entry per pop.
REQ-023 wb_valid = (count != 0); wb_data and wb_rd shall come from the head entry and hold stable while wb_valid=1 & wb_ready=0.
REQ-024 Simultaneous push and pop shall leave count unchanged and preserve FIFO order.
REQ-025 Read and write pointers shall wrap modulo DEPTH.
REQ-026 fu_finish with pend_v=0 shall be dropped and shall set err.
REQ-027 issue_en while div_busy=1 shall be ignored and shall set err.
REQ-028 err shall clear only on rst.
REQ-029 Latency, bypass disabled: result on wb_* the cycle after fu_finish.

Reset
REQ-030 When rst=1 at a clock edge, the block shall clear pend_v, both pointers, count and err.
REQ-031 After reset, outputs shall be: wb_valid=0, div_busy=0, count=0, err=0, wb_data=0, wb_rd=0.
REQ-032 Reset mid-operation shall discard the pending tag and all FIFO contents.
REQ-033 A fu_finish coincident with rst shall be discarded.
REQ-034 A fu_finish arriving after reset with pend_v=0 shall set err per REQ-026.

Configuration
REQ-035 Macro DIV_WB_BYPASS_EN, when defined: if count==0 and fu_finish & pend_v, then wb_valid=1, wb_data=fu_res, wb_rd=pend_rd in the same cycle.
REQ-036 Under DIV_WB_BYPASS_EN, a bypassed result that is accepted (wb_ready=1) shall not be pushed.
REQ-037 Under DIV_WB_BYPASS_EN, a bypassed result that is not accepted shall be pushed normally.
REQ-038 Macro DIV_WB_BYPASS_EN not defined: no combinational path from fu_* to wb_*; latency per REQ-029.

Verification
REQ-039 Reset, then issue_en=1 with issue_rd=7; fu_finish pulse with fu_res=0x00000005, wb_ready=1 -> next cycle wb_valid=1, wb_rd=7, wb_data=5; following cycle count=0.
REQ-040 With wb_ready=0, issue and complete 4 divides with tags 1..4 (data 0x10..0x13) -> count=4, div_busy=1; hold wb_ready=1 -> 4 pops in order 1..4 with matching data.
REQ-041 count=2 with the FIFO in WAIT state; fu_finish and a pop in the same cycle -> count stays 2 and order is preserved.
REQ-042 fu_finish with pend_v=0 -> err=1 and count unchanged; issue_en while busy -> pend_rd unchanged.
REQ-043 count=3 with pend_v=1; assert rst one cycle -> count=0, wb_valid=0, div_busy=0; a later fu_finish sets err.
REQ-044 Under DIV_WB_BYPASS_EN, FIFO empty, fu_finish with fu_res=0xDEADBEEF, wb_ready=1 -> wb_valid and data in the same cycle, count remains 0.
